bram_read_arbiter: RTL

Two-client read-port arbiter that sits directly upstream of a single-read-port BRAM with a two-entry output queue. It buffers one read request per client and issues requests to the BRAM in round-robin order. Issue order is kept in a tag FIFO, which routes each BRAM response back to the client that requested it, in order. The BRAM write port is not touched and is wired to its writer directly.

---
 rtl/bram_read_arbiter_if.sv | 31 +++
 rtl/bram_read_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bram_read_arbiter_if.sv
// Read channel bundle shared by the two clients and the BRAM port.
// Requests flow master->slave; responses flow slave->master.
interface bram_read_arbiter_if #(
    parameter int addr_width = 1,
    parameter int data_width = 1
);
    logic [addr_width-1:0] RD_ADDR;
    logic                  RD_EN;
    logic                  RD_RDY;
    logic [data_width-1:0] DOUT;
    logic                  DOUT_RDY;
    logic                  DOUT_EN;

    modport master (
        output RD_ADDR,
        output RD_EN,
        input  RD_RDY,
        input  DOUT,
        input  DOUT_RDY,
        output DOUT_EN
    );

    modport slave (
        input  RD_ADDR,
        input  RD_EN,
        output RD_RDY,
        output DOUT,
        output DOUT_RDY,
        input  DOUT_EN
    );
endinterface

// File: rtl/bram_read_arbiter.sv
// Two-client round-robin read arbiter in front of a single-port BRAM.
// A tag FIFO of client IDs steers in-order BRAM responses back.
module bram_read_arbiter #(
    parameter int addr_width    = 1,
    parameter int data_width    = 1,
    parameter int tag_depth     = 2,
    parameter int tag_ptr_width = 1
) (
    input logic                CLK,
    input logic                RST_N,
    bram_read_arbiter_if.slave  C0,
    bram_read_arbiter_if.slave  C1,
    bram_read_arbiter_if.master B
);

    localparam int cnt_width = tag_ptr_width + 1;

    localparam logic [tag_ptr_width-1:0] ptr_last =
        tag_ptr_width'(tag_depth - 1);

    localparam logic [cnt_width-1:0] cnt_full =
        cnt_width'(tag_depth);

    // Per-client request buffers
    logic [1:0]            buf_vld;
    logic [addr_width-1:0] buf_addr [2];

    // Round-robin history: client granted most recently
    logic                  last_grant;

    // Tag FIFO of client IDs in issue order
    logic [tag_depth-1:0]     tag_q;
    logic [tag_ptr_width-1:0] rd_ptr;
    logic [tag_ptr_width-1:0] wr_ptr;
    logic [cnt_width-1:0]     count;

    logic [1:0]            req_en;
    logic [addr_width-1:0] req_addr [2];

    logic grant_vld;
    logic grant_id;
    logic can_issue;
    logic issue;
    logic pop;
    logic head;
    logic has_tag;

    logic [tag_ptr_width-1:0] rd_ptr_nxt;
    logic [tag_ptr_width-1:0] wr_ptr_nxt;

    assign req_en      = {C1.RD_EN, C0.RD_EN};
    assign req_addr[0] = C0.RD_ADDR;
    assign req_addr[1] = C1.RD_ADDR;

    // Pick the requester; on contention prefer the one not served last
    always_comb begin
        grant_vld = |buf_vld;
        grant_id  = 1'b0;
        unique case (buf_vld)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    // Issue only from registered occupancy so a same-cycle pop never helps
    always_comb begin
        can_issue = B.RD_RDY && (count < cnt_full);
        issue     = can_issue && grant_vld;
    end

    // Wrapping pointer increments for the tag FIFO
    always_comb begin
        rd_ptr_nxt = rd_ptr + tag_ptr_width'(1);
        wr_ptr_nxt = wr_ptr + tag_ptr_width'(1);
        if (rd_ptr == ptr_last) begin
            rd_ptr_nxt = '0;
        end
        if (wr_ptr == ptr_last) begin
            wr_ptr_nxt = '0;
        end
    end

    assign B.RD_EN   = issue;
    assign B.RD_ADDR = buf_addr[grant_id];

    // Bypass refill: a buffer being drained this cycle may accept again
    assign C0.RD_RDY = !buf_vld[0] || (issue && !grant_id);
    assign C1.RD_RDY = !buf_vld[1] || (issue &&  grant_id);

    // Response steering is purely combinational off the tag head
    assign head    = tag_q[rd_ptr];
    assign has_tag = (count != '0);

    assign C0.DOUT_RDY = B.DOUT_RDY && has_tag && !head;
    assign C1.DOUT_RDY = B.DOUT_RDY && has_tag &&  head;
    assign C0.DOUT     = B.DOUT;
    assign C1.DOUT     = B.DOUT;

    assign pop       = C0.DOUT_EN | C1.DOUT_EN;
    assign B.DOUT_EN = pop;

    // Load buffers on request; drop the granted one unless refilled
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            buf_vld     <= '0;
            buf_addr[0] <= '0;
            buf_addr[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_en[i]) begin
                    buf_vld[i]  <= 1'b1;
                    buf_addr[i] <= req_addr[i];
                end else if (issue && (grant_id == i[0])) begin
                    buf_vld[i]  <= 1'b0;
                end
            end
        end
    end

    // Remember who was served; client 0 wins the first contention
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            last_grant <= 1'b1;
        end else if (issue) begin
            last_grant <= grant_id;
        end
    end

    // Tag FIFO: push granted ID on issue, pop on response dequeue
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tag_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (issue) begin
                tag_q[wr_ptr] <= grant_id;
                wr_ptr        <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            unique case ({issue, pop})
                2'b10:   count <= count + cnt_width'(1);
                2'b01:   count <= count - cnt_width'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
